// File: rtl/cache_pkg.sv
// Shared types, geometry and address helpers for the data-side cache controller.
package cache_pkg;

  localparam int unsigned INDEX_W = 6;
  localparam int unsigned OFFS_W  = 2;
  localparam int unsigned TAG_W   = 32 - INDEX_W - OFFS_W - 2;
  localparam int unsigned LINES   = 1 << INDEX_W;
  localparam int unsigned WORDS   = 1 << OFFS_W;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRefill = 2'd1,
    StWrite  = 2'd2
  } state_e;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] a);
    return a[OFFS_W+2 +: INDEX_W];
  endfunction

  function automatic logic [OFFS_W-1:0] addr_offs(input logic [31:0] a);
    return a[2 +: OFFS_W];
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return {a[31:OFFS_W+2], {(OFFS_W + 2){1'b0}}};
  endfunction

  // Byte lanes touched by a store; halfword lane chosen by addr[1].
  function automatic logic [3:0] store_be(input logic half, input logic upper);
    if (!half) return BE_WORD;
    return upper ? BE_HI : BE_LO;
  endfunction

  function automatic logic [31:0] half_sext(input logic [31:0] word, input logic upper);
    logic [15:0] h;
    h = upper ? word[31:16] : word[15:0];
    return {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays of the direct-mapped cache: async read, one byte-masked write port.
module cache_line_store
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] idx_i,
  input  logic [OFFS_W-1:0]  rd_offs_i,
  output logic               rd_valid_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [31:0]        rd_word_o,
  input  logic               wr_en_i,
  input  logic [OFFS_W-1:0]  wr_offs_i,
  input  logic [31:0]        wr_data_i,
  input  logic [3:0]         wr_be_i,
  input  logic               tag_set_i,
  input  logic [TAG_W-1:0]   tag_i,
  input  logic               inval_i
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][WORDS];

  assign rd_valid_o = valid_q[idx_i];
  assign rd_tag_o   = tag_q[idx_i];
  assign rd_word_o  = data_q[idx_i][rd_offs_i];

  // Valid bits: cleared wholesale on reset, set when a refill completes, dropped when one starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (tag_set_i) begin
      valid_q[idx_i] <= 1'b1;
    end else if (inval_i) begin
      valid_q[idx_i] <= 1'b0;
    end
  end

  // Tag array write at refill completion (not reset).
  always_ff @(posedge clk) begin
    if (tag_set_i) begin
      tag_q[idx_i] <= tag_i;
    end
  end

  // Data array byte-masked write (not reset).
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_i[b]) begin
          data_q[idx_i][wr_offs_i][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/cache_mem_ctrl.sv
// Data-cache sequencer: direct-mapped, write-through, no-write-allocate, full-line refill.
module cache_mem_ctrl
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic        cpu_half,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic [OFFS_W-1:0]  cnt_q, cnt_d;

  // Array lookups use the live CPU address in IDLE and the latched copy while busy.
  logic [31:0]        lk_addr;
  logic               line_valid;
  logic [TAG_W-1:0]   line_tag;
  logic [31:0]        line_word;
  logic               hit;

  logic               st_we;
  logic [OFFS_W-1:0]  st_offs;
  logic [31:0]        st_data;
  logic [3:0]         st_be;
  logic               st_tag_set;
  logic               st_inval;

  assign lk_addr = (state_q == StIdle) ? cpu_addr : addr_q;
  assign hit     = line_valid && (line_tag == addr_tag(lk_addr));

  cache_line_store u_store (
    .clk        (clk),
    .rst        (rst),
    .idx_i      (addr_index(lk_addr)),
    .rd_offs_i  (addr_offs(lk_addr)),
    .rd_valid_o (line_valid),
    .rd_tag_o   (line_tag),
    .rd_word_o  (line_word),
    .wr_en_i    (st_we),
    .wr_offs_i  (st_offs),
    .wr_data_i  (st_data),
    .wr_be_i    (st_be),
    .tag_set_i  (st_tag_set),
    .tag_i      (addr_tag(lk_addr)),
    .inval_i    (st_inval)
  );

  // State and latched request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, CPU-side response, memory request and array write control.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    cnt_d      = cnt_q;
    cpu_rdata  = '0;
    cpu_stall  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_be     = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    st_we      = 1'b0;
    st_offs    = cnt_q;
    st_data    = mem_rdata;
    st_be      = BE_WORD;
    st_tag_set = 1'b0;
    st_inval   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cpu_wr) begin
          // Store wins over a simultaneous load; sh data replicated so either lane is correct.
          cpu_stall = 1'b1;
          addr_d    = cpu_addr;
          wdata_d   = cpu_half ? {2{cpu_wdata[15:0]}} : cpu_wdata;
          be_d      = store_be(cpu_half, cpu_addr[1]);
          state_d   = StWrite;
        end else if (cpu_rd) begin
          if (hit) begin
            cpu_rdata = cpu_half ? half_sext(line_word, cpu_addr[1]) : line_word;
          end else begin
            cpu_stall = 1'b1;
            addr_d    = line_base(cpu_addr);
            cnt_d     = '0;
            st_inval  = 1'b1;
            state_d   = StRefill;
          end
        end
      end

      StRefill: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_be    = BE_WORD;
        mem_addr  = {addr_q[31:OFFS_W+2], cnt_q, 2'b00};
        if (mem_ready) begin
          st_we = 1'b1;
          cnt_d = cnt_q + OFFS_W'(1);
          if (cnt_q == '1) begin
            st_tag_set = 1'b1;
            state_d    = StIdle;
          end
        end
      end

      StWrite: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_be    = be_q;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wdata = wdata_q;
        cpu_stall = !mem_ready;
        st_offs   = addr_offs(addr_q);
        st_data   = wdata_q;
        st_be     = be_q;
        if (mem_ready) begin
          // No allocate: only a line already present is updated.
          st_we   = hit;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Reset forces the CPU-facing outputs quiet even if a load is still presented.
    if (rst) begin
      cpu_stall = 1'b0;
      cpu_rdata = '0;
    end
  end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Bench for cache_mem_ctrl: CPU driver + memory responder, scoreboard against a behavioural model.
module tb_cache_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic        cpu_half = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  cache_mem_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_half  (cpu_half),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mreq_t;

  mreq_t       exp_mem[$];
  logic [31:0] exp_rd[$];
  int          checks = 0;
  int          passed = 0;
  int          accepts = 0;
  int          wait_cycles = 0;

  logic [31:0] mem     [1024];  // memory behind the DUT, written only by DUT requests
  logic [31:0] ref_mem [1024];  // what memory should hold, per the reference model
  int          model_line [64]; // line address (addr>>4) resident per index, -1 if none

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  // Memory responder: after wait_cycles idle cycles completes each beat with mem_ready.
  initial begin : responder
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (cnt >= wait_cycles) begin
          cnt = 0;
          mem_ready = 1'b1;
          if (mem_we) begin
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) mem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          end else begin
            mem_rdata = mem[mem_addr[11:2]];
          end
        end else begin
          mem_ready = 1'b0;
          cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT completes a memory beat or answers a load.
  always @(negedge clk) begin : monitor
    mreq_t e;
    if (!rst) begin
      if (mem_req && mem_ready) begin
        accepts++;
        if (exp_mem.size() == 0) begin
          checks++;
          $display("FAIL mem_unexpected: got request at %h, expected none", mem_addr);
        end else begin
          e = exp_mem.pop_front();
          check("mem_we", 32'(mem_we), 32'(e.we));
          check("mem_addr", mem_addr, e.addr);
          check("mem_be", 32'(mem_be), 32'(e.be));
          if (e.we) check("mem_wdata", mem_wdata, e.wdata);
        end
      end
      if (cpu_rd && !cpu_wr && !cpu_stall) begin
        if (exp_rd.size() == 0) begin
          checks++;
          $display("FAIL rd_unexpected: got load data %h, expected none", cpu_rdata);
        end else begin
          check("cpu_rdata", cpu_rdata, exp_rd.pop_front());
          check("hit_mem_req", 32'(mem_req), 32'd0);
        end
      end
    end
  end

  // Issue one CPU op, update the model, hold it through the stall, compare stall length.
  task automatic do_op(input logic rd, input logic wr, input logic half,
                       input logic [31:0] addr, input logic [31:0] data, input int w);
    int          idx;
    int          la;
    int          exp_stall;
    int          n;
    logic [31:0] word;
    logic [15:0] hw;
    logic [3:0]  be;
    logic [31:0] wd;
    idx = int'(addr[9:4]);
    la  = int'(addr[31:4]);
    if (wr) begin
      be = half ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wd = half ? {data[15:0], data[15:0]} : data;
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[addr[11:2]][8*b +: 8] = wd[8*b +: 8];
      exp_mem.push_back('{1'b1, {addr[31:2], 2'b00}, be, wd});
      exp_stall = 1 + w;
    end else begin
      word = ref_mem[addr[11:2]];
      hw   = addr[1] ? word[31:16] : word[15:0];
      exp_rd.push_back(half ? {{16{hw[15]}}, hw} : word);
      if (model_line[idx] == la) begin
        exp_stall = 0;
      end else begin
        for (int k = 0; k < 4; k++)
          exp_mem.push_back('{1'b0, {addr[31:4], 4'b0000} + 32'(4 * k), 4'b1111, 32'h0});
        model_line[idx] = la;
        exp_stall = 1 + 4 * (w + 1);
      end
    end
    wait_cycles = w;
    cpu_rd = rd; cpu_wr = wr; cpu_half = half; cpu_addr = addr; cpu_wdata = data;
    n = 0;
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      n++;
      if (n > 400) begin
        checks++;
        $display("FAIL stall_timeout: got stall beyond 400 cycles at %h, expected release", addr);
        $display("%0d/%0d checks passed", passed, checks);
        $fatal(1, "stall timeout");
      end
      @(posedge clk);
      #1;
    end
    check("stall_cycles", 32'(n), 32'(exp_stall));
    @(posedge clk);
    #1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  // Load miss aborted by reset after its second refill beat; the same load must miss again.
  task automatic reset_mid_refill();
    int base;
    int n;
    base = accepts;
    wait_cycles = 0;
    for (int k = 0; k < 4; k++)
      exp_mem.push_back('{1'b0, 32'h0000_0C80 + 32'(4 * k), 4'b1111, 32'h0});
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_half = 1'b0; cpu_addr = 32'h0000_0C80;
    n = 0;
    while (accepts < base + 2 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    rst = 1'b1;
    #1;
    check("rst_beats_before", 32'(accepts - base), 32'd2);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    cpu_rd = 1'b0;
    exp_mem.delete();
    for (int i = 0; i < 64; i++) model_line[i] = -1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_op(1'b1, 1'b0, 1'b0, 32'h0000_0C80, 32'h0, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $display("%0d/%0d checks passed", passed, checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 64; i++) model_line[i] = -1;

    #1 rst = 1'b1;
    #2;
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    check("reset_mem_be", 32'(mem_be), 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);
    check("reset_cpu_stall", 32'(cpu_stall), 32'd0);
    check("reset_cpu_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Miss with zero-wait memory, then a hit in the same line.
    do_op(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 0);
    do_op(1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 0);
    // Halfword store into a resident line, then signed halfword load back.
    do_op(1'b0, 1'b1, 1'b1, 32'h0000_0042, 32'h0000_BEEF, 0);
    do_op(1'b1, 1'b0, 1'b1, 32'h0000_0042, 32'h0, 0);
    // Store miss with a slow memory: no allocate, so the following load misses.
    do_op(1'b0, 1'b1, 1'b0, 32'h0000_0800, 32'h1234_5678, 3);
    do_op(1'b1, 1'b0, 1'b0, 32'h0000_0800, 32'h0, 0);
    reset_mid_refill();
    // Simultaneous load+store: store only; then two conflicting lines evict each other.
    do_op(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 0);
    do_op(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 0);
    do_op(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 0);
    do_op(1'b1, 1'b0, 1'b0, 32'h0000_0440, 32'h0, 1);
    do_op(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 2);

    repeat (200) begin
      int          t;
      int          w;
      logic [31:0] a;
      t = int'($urandom_range(0, 4));
      w = int'($urandom_range(0, 2));
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4)
          | 32'($urandom_range(0, 15));
      case (t)
        0: do_op(1'b1, 1'b0, 1'b0, a, 32'h0, w);
        1: do_op(1'b1, 1'b0, 1'b1, a, 32'h0, w);
        2: do_op(1'b0, 1'b1, 1'b0, a, $urandom, w);
        3: do_op(1'b0, 1'b1, 1'b1, a, $urandom, w);
        default: do_op(1'b1, 1'b1, 1'($urandom_range(0, 1)), a, $urandom, w);
      endcase
    end

    repeat (3) @(posedge clk);
    check("mem_queue_drained", 32'(exp_mem.size()), 32'd0);
    check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
